// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg
//   Shared types for the stream arbiter/mux block.
//   arb_mode_e   : arbitration policy selected by the top-level parameter.
//   lock_state_e : packet-lock FSM state; also exposed on the debug port.
//   Widths remain module parameters, so none are defined here.
package stream_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational arbiter.
//   ARB_RR    : the search starts at ptr+1 and wraps modulo NCH.
//   ARB_FIXED : the search starts at index 0, so the lowest valid index wins.
// Ports:
//   req       [NCH]  : request vector.
//   ptr       [CH_W] : last channel served (used in ARB_RR only).
//   mode             : arbitration policy.
//   grant     [NCH]  : one-hot grant, all zero when there is no request.
//   grant_idx [CH_W] : encoded grant index, 0 when there is no request.
module rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  input  arb_mode_e       mode,
  output logic [NCH-1:0]  grant,
  output logic [CH_W-1:0] grant_idx
);

  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NCH; i++) begin
      if (mode == ARB_RR) idx = (int'(ptr) + 1 + i) % NCH;
      else                idx = i;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// stream_arb_mux
//   Merges NCH valid/ready input streams onto one registered output stream.
//   A grant is held for the whole of a multi-beat packet (in_last=0 beats).
//
// Handshake: a beat moves across an interface in any cycle in which both
//   valid and ready are high. in_ready depends combinationally on out_ready
//   and in_valid; out_valid never depends on out_ready. A producer holds its
//   data and last stable while valid is high and the beat is not yet taken.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset.
//   in_valid/in_ready      : per-channel handshake [NCH].
//   in_data                : channel k in bits [k*WIDTH +: WIDTH].
//   in_last                : per-channel end-of-packet [NCH].
//   out_valid/out_ready    : output handshake.
//   out_data, out_last     : registered beat.
//   out_ch                 : source channel of the registered beat.
//   dbg_lock_state         : current lock FSM state (observation only).
module stream_arb_mux
  import stream_arb_pkg::*;
#(
  parameter int        WIDTH    = 16,
  parameter int        NCH      = 4,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  parameter int        CH_W     = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]     in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [CH_W-1:0]    out_ch,
  output lock_state_e        dbg_lock_state
);

  lock_state_e       state, state_nxt;
  logic [CH_W-1:0]   lock_ch, lock_ch_nxt;
  logic [CH_W-1:0]   ptr;

  logic [NCH-1:0]    arb_grant;
  logic [CH_W-1:0]   arb_idx;
  logic [NCH-1:0]    grant;
  logic [CH_W-1:0]   grant_idx;

  logic              load;
  logic              acc;
  logic [WIDTH-1:0]  acc_data;
  logic              acc_last;

  rr_arbiter #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .mode      (ARB_MODE),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // The register can take a beat when empty or when it drains this cycle.
  assign load = !out_valid || out_ready;

  // Gated by rst_n so no beat is offered while reset is held.
  assign in_ready = grant & {NCH{load & rst_n}};
  assign acc      = |(in_valid & in_ready);

  // Mux the granted channel's beat; grant_idx is the single source of truth.
  always_comb begin
    acc_data = '0;
    acc_last = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_idx == CH_W'(k)) begin
        acc_data = in_data[k*WIDTH +: WIDTH];
        acc_last = in_last[k];
      end
    end
  end

  // Lock FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNLOCKED;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  // Lock FSM: next state.
  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    case (state)
      UNLOCKED: begin
        if (acc && !acc_last) begin
          state_nxt   = LOCKED;
          lock_ch_nxt = grant_idx;
        end
      end
      LOCKED: begin
        if (acc && acc_last) state_nxt = UNLOCKED;
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  // Lock FSM: outputs. While locked the grant stays on the owner even if it
  // drops valid, so no other channel can interleave into the packet.
  always_comb begin
    grant     = arb_grant;
    grant_idx = arb_idx;
    if (state == LOCKED) begin
      grant          = '0;
      grant[lock_ch] = 1'b1;
      grant_idx      = lock_ch;
    end
  end

  assign dbg_lock_state = state;

  // Round-robin pointer: moves only when a packet completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= CH_W'(NCH - 1);
    end else if (acc && acc_last) begin
      ptr <= grant_idx;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= acc;
      if (acc) begin
        out_data <= acc_data;
        out_last <= acc_last;
        out_ch   <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
module tb_stream_arb_mux;
  import stream_arb_pkg::*;

  localparam int W    = 16;
  localparam int NCH  = 4;
  localparam int CH_W = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic [NCH-1:0]   in_valid = '0;
  logic [NCH*W-1:0] in_data  = '0;
  logic [NCH-1:0]   in_last  = '0;
  logic             out_ready = 1'b1;

  // round-robin instance
  logic [NCH-1:0]  rr_in_ready;
  logic            rr_out_valid, rr_out_last;
  logic [W-1:0]    rr_out_data;
  logic [CH_W-1:0] rr_out_ch;
  lock_state_e     rr_state;

  // fixed-priority instance
  logic [NCH-1:0]  fx_in_ready;
  logic            fx_out_valid, fx_out_last;
  logic [W-1:0]    fx_out_data;
  logic [CH_W-1:0] fx_out_ch;
  lock_state_e     fx_state;

  stream_arb_mux #(.WIDTH(W), .NCH(NCH), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rr_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(rr_out_valid), .out_ready(out_ready), .out_data(rr_out_data),
    .out_last(rr_out_last), .out_ch(rr_out_ch), .dbg_lock_state(rr_state)
  );

  stream_arb_mux #(.WIDTH(W), .NCH(NCH), .ARB_MODE(ARB_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(fx_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(fx_out_valid), .out_ready(out_ready), .out_data(fx_out_data),
    .out_last(fx_out_last), .out_ch(fx_out_ch), .dbg_lock_state(fx_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic v, input logic last, input logic [W-1:0] d);
    in_valid[k]        = v;
    in_last[k]         = last;
    in_data[k*W +: W]  = d;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = '1;
    in_last   = '1;
    out_ready = 1'b1;
    #1;
    check("rst_rr_in_ready", 32'(rr_in_ready), 32'h0);
    check("rst_fx_in_ready", 32'(fx_in_ready), 32'h0);
    tick();
    tick();
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    rst_n    = 1'b1;
    #1;
  endtask

  initial begin
    logic [3:0] rr_ready_seq [5];
    logic [W-1:0] exp_d;
    rr_ready_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // 1. reset
    apply_reset();
    check("t1_out_valid", 32'(rr_out_valid), 32'h0);
    check("t1_in_ready",  32'(rr_in_ready),  32'h0);
    check("t1_out_ch",    32'(rr_out_ch),    32'h0);
    check("t1_out_data",  32'(rr_out_data),  32'h0);
    check("t1_state",     32'(rr_state),     32'(UNLOCKED));

    // 2. round-robin rotation, all channels single-beat
    for (int k = 0; k < NCH; k++) set_ch(k, 1'b1, 1'b1, W'(k));
    for (int k = 0; k < 5; k++) exp_q.push_back(W'(k % NCH));
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_in_ready", 32'(rr_in_ready), 32'(rr_ready_seq[i]));
      tick();
      exp_d = exp_q.pop_front();
      check("t2_out_valid", 32'(rr_out_valid), 32'h1);
      check("t2_out_data",  32'(rr_out_data),  32'(exp_d));
      check("t2_out_ch",    32'(rr_out_ch),    32'(i % NCH));
      check("t2_out_last",  32'(rr_out_last),  32'h1);
    end
    in_valid = '0;
    tick();
    check("t2_drain_valid", 32'(rr_out_valid), 32'h0);

    // 3. packet lock: ch2 sends 3 beats, ch1 waits
    apply_reset();
    set_ch(2, 1'b1, 1'b0, 16'h0021);
    #1;
    check("t3_b0_ready", 32'(rr_in_ready), 32'b0100);
    tick();
    check("t3_b0_data",  32'(rr_out_data), 32'h0021);
    check("t3_b0_ch",    32'(rr_out_ch),   32'h2);
    check("t3_locked",   32'(rr_state),    32'(LOCKED));
    set_ch(1, 1'b1, 1'b1, 16'h0010);
    set_ch(2, 1'b1, 1'b0, 16'h0022);
    #1;
    check("t3_b1_ready", 32'(rr_in_ready), 32'b0100);
    tick();
    check("t3_b1_data",  32'(rr_out_data), 32'h0022);
    check("t3_b1_last",  32'(rr_out_last), 32'h0);
    // owner drops valid for a cycle: grant must stay on ch2
    set_ch(2, 1'b0, 1'b0, 16'h0022);
    #1;
    check("t3_gap_ready", 32'(rr_in_ready), 32'b0100);
    tick();
    check("t3_gap_valid", 32'(rr_out_valid), 32'h0);
    set_ch(2, 1'b1, 1'b1, 16'h0023);
    #1;
    check("t3_b2_ready", 32'(rr_in_ready), 32'b0100);
    tick();
    check("t3_b2_data",  32'(rr_out_data), 32'h0023);
    check("t3_b2_last",  32'(rr_out_last), 32'h1);
    check("t3_unlocked", 32'(rr_state),    32'(UNLOCKED));
    set_ch(2, 1'b0, 1'b0, 16'h0000);
    #1;
    check("t3_ch1_ready", 32'(rr_in_ready), 32'b0010);
    tick();
    check("t3_ch1_data", 32'(rr_out_data), 32'h0010);
    check("t3_ch1_ch",   32'(rr_out_ch),   32'h1);
    in_valid = '0;
    tick();

    // 4. backpressure for 5 cycles
    apply_reset();
    set_ch(0, 1'b1, 1'b1, 16'h00A0);
    tick();
    check("t4_first_data", 32'(rr_out_data), 32'h00A0);
    set_ch(0, 1'b1, 1'b1, 16'h00A1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_hold_ready", 32'(rr_in_ready),  32'h0);
      tick();
      check("t4_hold_valid", 32'(rr_out_valid), 32'h1);
      check("t4_hold_data",  32'(rr_out_data),  32'h00A0);
      check("t4_hold_ch",    32'(rr_out_ch),    32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("t4_release_ready", 32'(rr_in_ready), 32'b0001);
    tick();
    check("t4_reload_valid", 32'(rr_out_valid), 32'h1);
    check("t4_reload_data",  32'(rr_out_data),  32'h00A1);
    in_valid = '0;
    tick();

    // 5. fixed priority: ch1 always beats ch3
    apply_reset();
    set_ch(1, 1'b1, 1'b1, 16'h0011);
    set_ch(3, 1'b1, 1'b1, 16'h0033);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_fx_ready", 32'(fx_in_ready), 32'b0010);
      tick();
      check("t5_fx_ch",   32'(fx_out_ch),   32'h1);
      check("t5_fx_data", 32'(fx_out_data), 32'h0011);
    end
    in_valid = '0;
    tick();

    // 6. reset in the middle of a packet
    apply_reset();
    set_ch(0, 1'b1, 1'b0, 16'h0005);
    tick();
    check("t6_locked",    32'(rr_state),     32'(LOCKED));
    check("t6_pre_valid", 32'(rr_out_valid), 32'h1);
    in_valid = '0;
    set_ch(3, 1'b1, 1'b1, 16'h003F);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(rr_out_valid), 32'h0);
    check("t6_rst_state", 32'(rr_state),     32'(UNLOCKED));
    check("t6_rst_ready", 32'(rr_in_ready),  32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_ch3_ready", 32'(rr_in_ready), 32'b1000);
    tick();
    check("t6_ch3_valid", 32'(rr_out_valid), 32'h1);
    check("t6_ch3_ch",    32'(rr_out_ch),    32'h3);
    check("t6_ch3_data",  32'(rr_out_data),  32'h003F);
    in_valid = '0;
    tick();

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
